ub_systolic_feeder: RTL and testbench

Read sequencer and de-skew front end that sits directly downstream of the unified buffer and feeds the systolic array.
- On a Start command it issues per-bank read requests to one unified-buffer read port.
- Bank b is delayed by b cycles, producing the diagonal wavefront the array needs.
- It returns the 1-cycle-latency read data to the array as per-lane data plus a per-lane valid.

---
 rtl/ub_feeder_pkg.sv | 30 +++
 rtl/ub_skew_chain.sv | 39 +++
 rtl/ub_systolic_feeder.sv | 167 ++++++++++++++++
 tb/tb_ub_systolic_feeder.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ub_feeder_pkg.sv
// Shared types, default sizes and width helpers for the unified-buffer systolic feeder.
package ub_feeder_pkg;

   localparam int UB_DATA_WIDTH = 8;
   localparam int UB_NUM_BANKS  = 16;
   localparam int UB_BANK_DEPTH = 4096;

   function automatic int row_bits_f(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // One extra bit so a burst can cover every row of a bank.
   function automatic int len_bits_f(input int depth);
      return row_bits_f(depth) + 1;
   endfunction

   localparam int UB_ROW_BITS = row_bits_f(UB_BANK_DEPTH);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      FINISH = 2'd2
   } state_e;

   typedef struct packed {
      logic                   valid;
      logic [UB_ROW_BITS-1:0] addr;
   } req_t;

endpackage

// File: rtl/ub_skew_chain.sv
// Shift register with global enable hold and both resets; stage i is the input delayed i+1 cycles.
module ub_skew_chain #(
   parameter int W      = 1,
   parameter int STAGES = 15
) (
   input  logic                     CLK,
   input  logic                     ASYNC_RST,
   input  logic                     SYNC_RST,
   input  logic                     EN,
   input  logic [W-1:0]             din,
   output logic [STAGES-1:0][W-1:0] dout
);

   logic [STAGES-1:0][W-1:0] stage_q;
   logic [STAGES-1:0][W-1:0] stage_d;

   always_comb begin
      stage_d = stage_q;
      if (SYNC_RST) begin
         stage_d = '0;
      end else if (EN) begin
         stage_d[0] = din;
         for (int i = 1; i < STAGES; i++) begin
            stage_d[i] = stage_q[i-1];
         end
      end
   end

   always_ff @(posedge CLK or negedge ASYNC_RST) begin
      if (!ASYNC_RST) begin
         stage_q <= '0;
      end else begin
         stage_q <= stage_d;
      end
   end

   assign dout = stage_q;

endmodule

// File: rtl/ub_systolic_feeder.sv
// Burst read sequencer for the unified buffer with a per-bank diagonal skew and lane-valid return path.
module ub_systolic_feeder
   import ub_feeder_pkg::*;
#(
   parameter int  DATA_WIDTH = UB_DATA_WIDTH,
   parameter int  NUM_BANKS  = UB_NUM_BANKS,
   parameter int  BANK_DEPTH = UB_BANK_DEPTH,
   localparam int ROW_BITS   = row_bits_f(BANK_DEPTH),
   localparam int LEN_BITS   = len_bits_f(BANK_DEPTH)
) (
   input  logic                                 CLK,
   input  logic                                 ASYNC_RST,
   input  logic                                 SYNC_RST,
   input  logic                                 EN,
   input  logic                                 Start,
   input  logic [ROW_BITS-1:0]                  StartAddress,
   input  logic [LEN_BITS-1:0]                  Length,
   output logic                                 Busy,
   output logic                                 Done,
   output logic [NUM_BANKS-1:0]                 ReadValid,
   output logic [NUM_BANKS-1:0][ROW_BITS-1:0]   ReadAddress,
   input  logic signed [NUM_BANKS-1:0][DATA_WIDTH-1:0] ReadData,
   output logic [NUM_BANKS-1:0]                 LaneValid,
   output logic signed [NUM_BANKS-1:0][DATA_WIDTH-1:0] LaneData
);

   localparam int CNT_BITS = $clog2(BANK_DEPTH + NUM_BANKS);
   localparam int SKEW     = NUM_BANKS - 1;

   state_e              state_q, state_d;
   logic [LEN_BITS-1:0] rem_q, rem_d;
   logic [CNT_BITS-1:0] cnt_q, cnt_d;
   logic [CNT_BITS-1:0] last_q, last_d;
   logic                zero_q, zero_d;
   req_t                head_q, head_d;
   logic                lane0_q, lane0_d;

   req_t [SKEW-1:0]     req_skew;
   logic [SKEW-1:0]     lane_skew;
   logic [NUM_BANKS-1:0] lane_valid;

   // cnt counts enabled cycles since Start; the last lane's final beat lands when it reaches last.
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      zero_d  = zero_q;
      head_d  = head_q;
      lane0_d = lane0_q;
      if (SYNC_RST) begin
         state_d = IDLE;
         rem_d   = '0;
         cnt_d   = '0;
         last_d  = '0;
         zero_d  = 1'b0;
         head_d  = '0;
         lane0_d = 1'b0;
      end else if (EN) begin
         lane0_d = head_q.valid;
         case (state_q)
            RUN: begin
               cnt_d = cnt_q + CNT_BITS'(1);
               if (rem_q != '0) begin
                  head_d.valid = 1'b1;
                  head_d.addr  = head_q.addr + UB_ROW_BITS'(1);
                  rem_d        = rem_q - LEN_BITS'(1);
               end else begin
                  head_d.valid = 1'b0;
               end
               if (cnt_q == last_q) begin
                  state_d = FINISH;
               end
            end
            default: begin
               // FINISH is the Done cycle and accepts a new Start just like IDLE.
               state_d = IDLE;
               zero_d  = 1'b0;
               head_d  = '0;
               if (Start) begin
                  cnt_d = '0;
                  if (Length != '0) begin
                     state_d      = RUN;
                     head_d.valid = 1'b1;
                     head_d.addr  = StartAddress;
                     rem_d        = Length - LEN_BITS'(1);
                     last_d       = CNT_BITS'(Length) + CNT_BITS'(NUM_BANKS - 2);
                  end else begin
                     state_d = FINISH;
                     zero_d  = 1'b1;
                  end
               end
            end
         endcase
      end
   end

   always_ff @(posedge CLK or negedge ASYNC_RST) begin
      if (!ASYNC_RST) begin
         state_q <= IDLE;
         rem_q   <= '0;
         cnt_q   <= '0;
         last_q  <= '0;
         zero_q  <= 1'b0;
         head_q  <= '0;
         lane0_q <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         zero_q  <= zero_d;
         head_q  <= head_d;
         lane0_q <= lane0_d;
      end
   end

   ub_skew_chain #(
      .W      ($bits(req_t)),
      .STAGES (SKEW)
   ) u_req_skew (
      .CLK       (CLK),
      .ASYNC_RST (ASYNC_RST),
      .SYNC_RST  (SYNC_RST),
      .EN        (EN),
      .din       (head_q),
      .dout      (req_skew)
   );

   // LaneValid[b] trails LaneValid[b-1] by one cycle, same as the request skew.
   ub_skew_chain #(
      .W      (1),
      .STAGES (SKEW)
   ) u_lane_skew (
      .CLK       (CLK),
      .ASYNC_RST (ASYNC_RST),
      .SYNC_RST  (SYNC_RST),
      .EN        (EN),
      .din       (lane0_q),
      .dout      (lane_skew)
   );

   assign lane_valid = {lane_skew, lane0_q};

   always_comb begin
      ReadValid      = '0;
      ReadAddress    = '0;
      ReadValid[0]   = head_q.valid;
      ReadAddress[0] = head_q.addr;
      for (int b = 1; b < NUM_BANKS; b++) begin
         ReadValid[b]   = req_skew[b-1].valid;
         ReadAddress[b] = req_skew[b-1].addr;
      end
   end

   always_comb begin
      LaneData = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         LaneData[b] = lane_valid[b] ? ReadData[b] : '0;
      end
   end

   assign LaneValid = lane_valid;
   assign Busy      = (state_q == RUN) || ((state_q == FINISH) && !zero_q);
   assign Done      = (state_q == FINISH);

endmodule

// File: tb/tb_ub_systolic_feeder.sv
// Directed bench for ub_systolic_feeder with a preloaded unified-buffer model and hand-derived timing.
`timescale 1ns/1ps
module tb_ub_systolic_feeder;

   localparam int NB = 16;
   localparam int DW = 8;
   localparam int RB = 12;
   localparam int LB = 13;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic sync_rst = 1'b0;
   logic en = 1'b0;
   logic start = 1'b0;
   logic [RB-1:0] start_addr = '0;
   logic [LB-1:0] length = '0;
   logic busy, done;
   logic [NB-1:0] rv, lv;
   logic [NB-1:0][RB-1:0] ra;
   logic signed [NB-1:0][DW-1:0] rdata = '0;
   logic signed [NB-1:0][DW-1:0] ldata;

   logic [NB-1:0] e_rv, e_lv;
   logic [NB-1:0][DW-1:0] e_ld;
   logic e_busy, e_done;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   ub_systolic_feeder dut (
      .CLK          (clk),
      .ASYNC_RST    (rst_n),
      .SYNC_RST     (sync_rst),
      .EN           (en),
      .Start        (start),
      .StartAddress (start_addr),
      .Length       (length),
      .Busy         (busy),
      .Done         (done),
      .ReadValid    (rv),
      .ReadAddress  (ra),
      .ReadData     (rdata),
      .LaneValid    (lv),
      .LaneData     (ldata)
   );

   // Unified buffer: bank b row r holds (b*16+r) mod 128, one-cycle read latency, holds with EN low.
   always @(posedge clk) begin
      if (en) begin
         for (int b = 0; b < NB; b++) begin
            if (rv[b]) rdata[b] <= DW'((b * 16 + int'(ra[b])) % 128);
         end
      end
   end

   // Expected outputs j enabled cycles after the Start edge of a burst (a, l).
   function automatic void exp_at(input int a, input int l, input int j);
      e_rv = '0;
      e_lv = '0;
      e_ld = '0;
      for (int b = 0; b < NB; b++) begin
         if (j >= b && j < b + l) e_rv[b] = 1'b1;
         if (j >= b + 1 && j <= b + l) begin
            e_lv[b] = 1'b1;
            e_ld[b] = DW'((b * 16 + (a + j - b - 1) % 4096) % 128);
         end
      end
      e_busy = (l > 0) && (j <= NB - 1 + l);
      e_done = (l == 0) ? (j == 0) : (j == NB - 1 + l);
   endfunction

   task automatic issue(input int a, input int l);
      @(negedge clk);
      start = 1'b1;
      start_addr = RB'(a);
      length = LB'(l);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      en = 1'b1;
      repeat (2) @(negedge clk);
      total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL reset_busy_done got=%b exp=00", {busy, done}); end
      total++; if (rv !== '0 || lv !== '0) begin bad++; $display("FAIL reset_valids rv=%h lv=%h exp=0", rv, lv); end
      total++; if (ra !== '0 || ldata !== '0) begin bad++; $display("FAIL reset_addr_data ra=%h ld=%h exp=0", ra, ldata); end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      total++; if ({busy, done} !== 2'b00 || rv !== '0) begin bad++; $display("FAIL idle_after_reset busy_done=%b rv=%h exp=0", {busy, done}, rv); end
   endtask

   task automatic test_basic();
      issue(10, 3);
      for (int j = 0; j <= 20; j++) begin
         exp_at(10, 3, j);
         total++; if (busy !== e_busy) begin bad++; $display("FAIL basic_busy j=%0d got=%b exp=%b", j, busy, e_busy); end
         total++; if (done !== e_done) begin bad++; $display("FAIL basic_done j=%0d got=%b exp=%b", j, done, e_done); end
         total++; if (rv !== e_rv) begin bad++; $display("FAIL basic_rv j=%0d got=%h exp=%h", j, rv, e_rv); end
         total++; if (lv !== e_lv) begin bad++; $display("FAIL basic_lv j=%0d got=%h exp=%h", j, lv, e_lv); end
         total++; if (ldata !== e_ld) begin bad++; $display("FAIL basic_ld j=%0d got=%h exp=%h", j, ldata, e_ld); end
         for (int b = 0; b < NB; b++) if (e_rv[b]) begin
            total++; if (ra[b] !== RB'((10 + j - b) % 4096)) begin bad++; $display("FAIL basic_addr j=%0d b=%0d got=%0d exp=%0d", j, b, ra[b], (10 + j - b) % 4096); end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_wrap();
      issue(4094, 4);
      for (int j = 0; j <= 21; j++) begin
         exp_at(4094, 4, j);
         total++; if (rv !== e_rv) begin bad++; $display("FAIL wrap_rv j=%0d got=%h exp=%h", j, rv, e_rv); end
         total++; if (ldata !== e_ld) begin bad++; $display("FAIL wrap_ld j=%0d got=%h exp=%h", j, ldata, e_ld); end
         total++; if (done !== e_done) begin bad++; $display("FAIL wrap_done j=%0d got=%b exp=%b", j, done, e_done); end
         for (int b = 0; b < NB; b++) if (e_rv[b]) begin
            total++; if (ra[b] !== RB'((4094 + j - b) % 4096)) begin bad++; $display("FAIL wrap_addr j=%0d b=%0d got=%0d exp=%0d", j, b, ra[b], (4094 + j - b) % 4096); end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_zero_len();
      issue(5, 0);
      for (int j = 0; j <= 4; j++) begin
         exp_at(5, 0, j);
         total++; if (done !== e_done) begin bad++; $display("FAIL zero_done j=%0d got=%b exp=%b", j, done, e_done); end
         total++; if (busy !== 1'b0) begin bad++; $display("FAIL zero_busy j=%0d got=%b exp=0", j, busy); end
         total++; if (rv !== '0 || lv !== '0) begin bad++; $display("FAIL zero_valids j=%0d rv=%h lv=%h exp=0", j, rv, lv); end
         @(negedge clk);
      end
   endtask

   task automatic test_en_hold();
      int j = 0;
      int done_c = -1;
      issue(50, 3);
      for (int c = 0; c <= 24; c++) begin
         exp_at(50, 3, j);
         total++; if (busy !== e_busy) begin bad++; $display("FAIL hold_busy c=%0d got=%b exp=%b", c, busy, e_busy); end
         total++; if (done !== e_done) begin bad++; $display("FAIL hold_done c=%0d got=%b exp=%b", c, done, e_done); end
         total++; if (rv !== e_rv) begin bad++; $display("FAIL hold_rv c=%0d got=%h exp=%h", c, rv, e_rv); end
         total++; if (lv !== e_lv) begin bad++; $display("FAIL hold_lv c=%0d got=%h exp=%h", c, lv, e_lv); end
         total++; if (ldata !== e_ld) begin bad++; $display("FAIL hold_ld c=%0d got=%h exp=%h", c, ldata, e_ld); end
         if (done === 1'b1 && done_c < 0) done_c = c;
         en = !(c >= 4 && c < 7);
         @(negedge clk);
         if (en) j++;
      end
      en = 1'b1;
      total++; if (done_c != 21) begin bad++; $display("FAIL hold_done_cycle got=%0d exp=21", done_c); end
   endtask

   task automatic test_back_to_back();
      issue(20, 2);
      for (int j = 0; j <= 17; j++) begin
         exp_at(20, 2, j);
         total++; if (done !== e_done) begin bad++; $display("FAIL b2b_first_done j=%0d got=%b exp=%b", j, done, e_done); end
         total++; if (ldata !== e_ld) begin bad++; $display("FAIL b2b_first_ld j=%0d got=%h exp=%h", j, ldata, e_ld); end
         if (j == 17) begin
            start = 1'b1;
            start_addr = RB'(40);
            length = LB'(2);
         end
         @(negedge clk);
      end
      start = 1'b0;
      for (int j = 0; j <= 19; j++) begin
         exp_at(40, 2, j);
         total++; if (busy !== e_busy) begin bad++; $display("FAIL b2b_second_busy j=%0d got=%b exp=%b", j, busy, e_busy); end
         total++; if (done !== e_done) begin bad++; $display("FAIL b2b_second_done j=%0d got=%b exp=%b", j, done, e_done); end
         total++; if (rv !== e_rv) begin bad++; $display("FAIL b2b_second_rv j=%0d got=%h exp=%h", j, rv, e_rv); end
         total++; if (ldata !== e_ld) begin bad++; $display("FAIL b2b_second_ld j=%0d got=%h exp=%h", j, ldata, e_ld); end
         @(negedge clk);
      end
   endtask

   task automatic test_async_reset();
      issue(0, 8);
      for (int j = 0; j <= 4; j++) begin
         exp_at(0, 8, j);
         total++; if (rv !== e_rv) begin bad++; $display("FAIL areset_pre_rv j=%0d got=%h exp=%h", j, rv, e_rv); end
         @(negedge clk);
      end
      #2 rst_n = 1'b0;
      #1;
      total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL areset_busy_done got=%b exp=00", {busy, done}); end
      total++; if (rv !== '0 || lv !== '0) begin bad++; $display("FAIL areset_valids rv=%h lv=%h exp=0", rv, lv); end
      total++; if (ra !== '0 || ldata !== '0) begin bad++; $display("FAIL areset_addr_data ra=%h ld=%h exp=0", ra, ldata); end
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         total++; if (done !== 1'b0) begin bad++; $display("FAIL areset_no_done c=%0d got=%b exp=0", c, done); end
      end
      rst_n = 1'b1;
      issue(0, 1);
      for (int j = 0; j <= 18; j++) begin
         exp_at(0, 1, j);
         total++; if (busy !== e_busy) begin bad++; $display("FAIL areset_after_busy j=%0d got=%b exp=%b", j, busy, e_busy); end
         total++; if (done !== e_done) begin bad++; $display("FAIL areset_after_done j=%0d got=%b exp=%b", j, done, e_done); end
         total++; if (ldata !== e_ld) begin bad++; $display("FAIL areset_after_ld j=%0d got=%h exp=%h", j, ldata, e_ld); end
         @(negedge clk);
      end
   endtask

   task automatic test_start_busy_sync_rst();
      issue(100, 5);
      for (int j = 0; j <= 22; j++) begin
         if (j == 3) start = 1'b0;
         exp_at(100, 5, j);
         total++; if (done !== e_done) begin bad++; $display("FAIL ignore_done j=%0d got=%b exp=%b", j, done, e_done); end
         total++; if (rv !== e_rv) begin bad++; $display("FAIL ignore_rv j=%0d got=%h exp=%h", j, rv, e_rv); end
         total++; if (ldata !== e_ld) begin bad++; $display("FAIL ignore_ld j=%0d got=%h exp=%h", j, ldata, e_ld); end
         for (int b = 0; b < NB; b++) if (e_rv[b]) begin
            total++; if (ra[b] !== RB'(100 + j - b)) begin bad++; $display("FAIL ignore_addr j=%0d b=%0d got=%0d exp=%0d", j, b, ra[b], 100 + j - b); end
         end
         if (j == 2) begin
            start = 1'b1;
            start_addr = RB'(200);
            length = LB'(2);
         end
         @(negedge clk);
      end
      issue(300, 4);
      for (int j = 0; j <= 2; j++) begin
         exp_at(300, 4, j);
         total++; if (rv !== e_rv) begin bad++; $display("FAIL srst_pre_rv j=%0d got=%h exp=%h", j, rv, e_rv); end
         @(negedge clk);
      end
      en = 1'b0;
      sync_rst = 1'b1;
      @(negedge clk);
      total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL srst_busy_done got=%b exp=00", {busy, done}); end
      total++; if (rv !== '0 || lv !== '0) begin bad++; $display("FAIL srst_valids rv=%h lv=%h exp=0", rv, lv); end
      total++; if (ra !== '0 || ldata !== '0) begin bad++; $display("FAIL srst_addr_data ra=%h ld=%h exp=0", ra, ldata); end
      sync_rst = 1'b0;
      en = 1'b1;
      for (int c = 0; c < 18; c++) begin
         @(negedge clk);
         total++; if ({busy, done} !== 2'b00 || rv !== '0) begin bad++; $display("FAIL srst_abandoned c=%0d busy_done=%b rv=%h exp=0", c, {busy, done}, rv); end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_wrap();
      test_zero_len();
      test_en_hold();
      test_back_to_back();
      test_async_reset();
      test_start_busy_sync_rst();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
